rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback sources:
//  A = main pipeline writeback (single-cycle ops), B = long-latency unit (load/mul-div).
//  Registers the winning request onto rf_we/rf_wr/rf_wd, which drive the register file's we/wR/wD.
//  Keeps a 32-bit pending-write scoreboard for B-issued destinations; decode stalls on it.
// PARAMETERS
//  MAX_WAIT  4   cycles B may be refused while valid before it is force-granted (>=1)
//  WAIT_W    $clog2(MAX_WAIT+1)  wait-counter width (derived, do not override)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active-low
//  a_valid    in   1   source A has a write
//  a_ready    out  1   A write accepted this cycle
//  a_wr       in   5   A destination register
//  a_wd       in   32  A write data
//  b_valid    in   1   source B has a write
//  b_ready    out  1   B write accepted this cycle
//  b_wr       in   5   B destination register
//  b_wd       in   32  B write data
//  alloc_en   in   1   B-unit op issued this cycle; mark alloc_rd pending
//  alloc_rd   in   5   destination of issued B op
//  pending    out  32  bit i = register i awaits a B write; bit 0 always 0
//  rf_we      out  1   registered write enable to RF
//  rf_wr      out  5   registered write address to RF
//  rf_wd      out  32  registered write data to RF
// BEHAVIOUR
//  - Reset (rst_n=0, async): rf_we=0, rf_wr=0, rf_wd=0, pending=0, wait_cnt=0, stats=0.
//    In-flight requests are dropped; sources must re-present after reset.
//  - Handshake: transfer when valid&&ready at a rising edge. Ready is combinational.
//    Payload must hold while valid&&!ready.
//  - force_b = b_valid && (wait_cnt==MAX_WAIT).
//    a_ready = !force_b.  b_ready = force_b || !a_valid.
//  - Priority: A over B unless force_b. Exactly one grant per cycle, never both.
//  - wait_cnt increments on b_valid&&!b_ready, saturating at MAX_WAIT.
//    It clears on a B handshake or when b_valid=0.
//  - Output stage, latency 1: next edge after the handshake, rf_we=1 and rf_wr/rf_wd = winner's payload.
//    The RF commits one edge later.
//    No handshake: rf_we=0; rf_wr and rf_wd hold their previous values.
//  - x0 filter: a handshake with wr==0 is accepted and consumed but gives rf_we=0.
//    Such a write never touches pending.
//  - Output stage records its source (src_b).
//  - Scoreboard:
//    - Set: alloc_en && alloc_rd!=0 sets pending[alloc_rd] at the edge.
//    - Clear: rf_we && src_b clears pending[rf_wr] at the edge; this is the RF commit edge.
//    - Same register, same edge: set wins, because the newly issued op owns the register.
//    - alloc_rd==0 is ignored.
//    - A writes never modify pending. Decode is responsible for not issuing A writes to pending registers.
//  - Both sources targeting the same register in one cycle: only the granted one proceeds. No merging.
// CONFIGURATION
//  WBARB_STATS_EN defined:
//    - Adds output port conflict_cnt [15:0]: counts cycles with a_valid&&b_valid.
//    - Adds output port force_cnt [15:0]: counts force_b grants.
//    - Both counters saturate at 16'hFFFF and reset to 0.
//  WBARB_STATS_EN undefined: neither port exists and no counter logic is built.
//    Arbitration behaviour is identical in both builds.
// TESTING
//  1. Reset: rst_n=0 mid-transfer (a_valid=1, a_wr=5).
//     -> rf_we=0 and pending=0 immediately, with no clock edge.
//  2. A only: a_valid=1, a_wr=3, a_wd=32'hDEAD_BEEF -> a_ready=1.
//     -> Next cycle rf_we=1, rf_wr=3, rf_wd=32'hDEAD_BEEF. The following cycle rf_we=0.
//  3. Conflict: a_valid=b_valid=1 held, MAX_WAIT=4.
//     -> b_ready=0 for 4 cycles, then force grant: b_ready=1, a_ready=0.
//     -> Next cycle rf_wr=b_wr. A is granted the cycle after that.
//  4. Scoreboard: alloc_en with alloc_rd=7 -> pending[7]=1.
//     -> B write to 7 handshakes; pending[7] clears on the edge where rf_we=1, rf_wr=7.
//  5. Set/clear collision: B commit to reg 9 on the same edge as alloc_rd=9 -> pending[9] stays 1.
//     alloc_rd=0 -> pending unchanged.
//  6. x0: a_wr=0, a_valid=1 -> a_ready=1, next cycle rf_we=0.
//     WBARB_STATS_EN build, scenario 3 -> force_cnt=1, conflict_cnt=5.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-source writeback arbiter for the single register-file
// write port. Source A (main pipeline) has priority. Source B (long-latency
// unit) is force-granted after MAX_WAIT refused cycles. The winning write is
// registered onto rf_we/rf_wr/rf_wd one cycle after the handshake. A 32-bit
// pending-write scoreboard tracks B-unit destinations for decode stalls.
// Optional build macro WBARB_STATS_EN adds conflict_cnt/force_cnt counters.
//
// Handshake: a write transfers when valid && ready at a rising clk edge.
// ready is combinational from valid and wait state. The payload must stay
// stable while valid && !ready.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_wr,
  input  logic [31:0] a_wd,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_wr,
  input  logic [31:0] b_wd,
  input  logic        alloc_en,
  input  logic [4:0]  alloc_rd,
  output logic [31:0] pending,
`ifdef WBARB_STATS_EN
  output logic [15:0] conflict_cnt,
  output logic [15:0] force_cnt,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_rf_we;
  logic [4:0]        r_rf_wr;
  logic [31:0]       r_rf_wd;
  logic              r_src_b;
  logic [31:0]       r_pending;

  logic              w_force_b;
  logic              w_a_hs;
  logic              w_b_hs;
  logic [31:0]       w_pend_next;

  // B has waited long enough: it takes the port regardless of A.
  assign w_force_b = b_valid && (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign a_ready   = !w_force_b;
  assign b_ready   = w_force_b || !a_valid;
  assign w_a_hs    = a_valid && a_ready;
  assign w_b_hs    = b_valid && b_ready;

  assign rf_we   = r_rf_we;
  assign rf_wr   = r_rf_wr;
  assign rf_wd   = r_rf_wd;
  assign pending = r_pending;

  // Wait counter: counts refused B cycles, saturating; clears on grant or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!b_valid || w_b_hs) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Output stage: register the winner; writes to x0 are consumed silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we <= 1'b0;
      r_rf_wr <= '0;
      r_rf_wd <= '0;
      r_src_b <= 1'b0;
    end else if (w_b_hs) begin
      r_rf_we <= (b_wr != 5'd0);
      r_src_b <= 1'b1;
      if (b_wr != 5'd0) begin
        r_rf_wr <= b_wr;
        r_rf_wd <= b_wd;
      end
    end else if (w_a_hs) begin
      r_rf_we <= (a_wr != 5'd0);
      r_src_b <= 1'b0;
      if (a_wr != 5'd0) begin
        r_rf_wr <= a_wr;
        r_rf_wd <= a_wd;
      end
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  // Scoreboard next state: clear on B commit, then set on issue (set wins).
  always_comb begin
    w_pend_next = r_pending;
    if (r_rf_we && r_src_b) begin
      w_pend_next[r_rf_wr] = 1'b0;
    end
    if (alloc_en && (alloc_rd != 5'd0)) begin
      w_pend_next[alloc_rd] = 1'b1;
    end
    w_pend_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_next;
    end
  end

`ifdef WBARB_STATS_EN
  logic [15:0] r_conflict_cnt;
  logic [15:0] r_force_cnt;

  assign conflict_cnt = r_conflict_cnt;
  assign force_cnt    = r_force_cnt;

  // Saturating statistics: cycles with both sources valid, and forced B grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
      r_force_cnt    <= '0;
    end else begin
      if (a_valid && b_valid && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
      if (w_force_b && (r_force_cnt != 16'hFFFF)) begin
        r_force_cnt <= r_force_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
